regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side front end of the 32x32 register file. It owns the single write port (RW/DA/BUS_D) and
//  merges two result sources: the ALU pipe (fixed slot, no backpressure) and the load/store unit
//  (valid/ready, variable latency). LSU results queue in a small FIFO.
//  It also supplies operand bypass and RAW-hazard flags to decode, because the register file
//  commits on posedge and reads combinationally.
// PARAMETERS
//  DEPTH   4   LSU result FIFO entries (power of 2, >=2)
//  DW      32  data width
//  AW      5   register address width
// PORTS
//  clk         in   1   clock, posedge
//  rst_n       in   1   async active-low reset
//  alu_valid   in   1   ALU result present this cycle (cannot be stalled)
//  alu_da      in   AW  ALU destination register
//  alu_data    in   DW  ALU result
//  lsu_valid   in   1   LSU result offered
//  lsu_ready   out  1   FIFO can accept (= !full); transfer on valid&ready
//  lsu_da      in   AW  LSU destination register
//  lsu_data    in   DW  LSU result
//  RW          out  1   register-file write enable (registered)
//  DA          out  AW  register-file write address (registered)
//  BUS_D       out  DW  register-file write data (registered)
//  AA, BA      in   AW  decode read addresses (same as register file)
//  fwd_a_hit   out  1   RW && DA==AA && AA!=0; use fwd_a_data instead of A_data
//  fwd_a_data  out  DW  = BUS_D
//  fwd_b_hit   out  1   same for BA
//  fwd_b_data  out  DW  = BUS_D
//  raw_hazard  out  1   a valid FIFO entry's da equals a nonzero AA or BA; decode must stall
//  wb_full     out  1   FIFO full; pipeline must insert an ALU bubble next cycle
// BEHAVIOUR
//  - Reset (async): RW=0, DA=0, BUS_D=0, FIFO empty, lsu_ready=1, all hit/hazard outputs 0.
//  - Output register per cycle: if alu_valid, {RW,DA,BUS_D} <= {1,alu_da,alu_data}; else if FIFO
//    non-empty, pop head into the output register; else RW<=0 (DA/BUS_D hold).
//  - Latency: ALU result is presented 1 cycle after input. A FIFO push at cycle N is poppable at N+1
//    at the earliest, so it is presented at N+2 at the earliest. No same-cycle pass-through.
//  - Writes with da==0 are dropped at entry and never reach RW, FIFO or hazard logic.
//  - Ordering: ALU results are newer than anything queued. An accepted alu_valid with da=X clears
//    the valid bit of every FIFO entry with da==X; cleared entries pop silently with RW=0 and cost
//    one drain cycle.
//  - If an LSU transfer occurs in the same cycle with lsu_da==X, the handshake completes but the
//    entry is discarded.
//  - Full: lsu_ready=0. A push and a pop in the same cycle while full is not permitted; ready is
//    computed from the registered count only.
//  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH and uses AW-independent width $clog2(DEPTH)+1.
//  - Reset mid-operation drops all queued entries, and RW deasserts immediately (async).
// CONFIGURATION
//  WB_STATS_EN defined: adds outputs stat_squash[15:0] (entries killed by ALU overwrite) and
//    stat_full[15:0] (cycles with wb_full=1). Both saturate at 16'hFFFF and clear on reset.
//  WB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package regfile_pkg: DW/AW constants and the struct wb_entry_t {logic vld; logic [AW-1:0] da;
//    logic [DW-1:0] data;}.
//  One sub-module, wb_fifo: DEPTH-entry FIFO with a per-entry squash-by-address port and a parallel
//    da/vld compare bus for hazard detection.
//  The top level holds arbitration, the output register and the bypass logic.
// TESTING
//  1 ALU only: alu_valid, da=3, data=32'hDEAD_BEEF -> next cycle RW=1, DA=3, BUS_D=DEADBEEF;
//    with AA=3, fwd_a_hit=1.
//  2 LSU while ALU idle: push da=7, data=5 at N -> RW=1, DA=7 at N+2. raw_hazard=1 with BA=7 during
//    N+1; it clears once the entry is popped into the output register.
//  3 Fill: ALU busy every cycle while the LSU pushes 4 entries -> wb_full=1, lsu_ready=0. One ALU bubble
//    -> one pop; ready returns the next cycle.
//  4 Squash: queued da=9 data=1, then ALU da=9 data=2 -> only the {9,2} write is seen (RW=1).
//    The squashed slot drains with RW=0. Under WB_STATS_EN, stat_squash=1.
//  5 R0: alu_da=0 and an lsu_da=0 transfer -> RW stays 0, no FIFO occupancy, no hits or hazards.
//  6 Reset while 3 entries are queued and RW=1 -> RW=0 asynchronously; empty and lsu_ready=1 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the write-back entry payload for the register-file write side.
package regfile_pkg;

   localparam int unsigned DW       = 32;
   localparam int unsigned AW       = 5;
   localparam int unsigned WB_DEPTH = 4;

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] da;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// LSU result queue with squash-by-address and a parallel vld/da compare bus.
// Popped and squashed slots have their vld cleared, so vld_o marks exactly the live entries.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  wb_entry_t                    push_entry_i,
   input  logic                         pop_i,
   input  logic                         squash_i,
   input  logic [AW-1:0]                squash_da_i,
   output wb_entry_t                    head_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [DEPTH-1:0]             vld_o,
   output logic [DEPTH-1:0][AW-1:0]     da_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   // Squash first, then pop/push; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (squash_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[PW'(i)].vld && (mem_q[PW'(i)].da == squash_da_i)) begin
               mem_d[PW'(i)].vld = 1'b0;
            end
         end
      end
      if (pop_i) begin
         mem_d[rd_q].vld = 1'b0;
         rd_d            = rd_q + PW'(1);
      end
      if (push_i) begin
         mem_d[wr_q] = push_entry_i;
         wr_d        = wr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      vld_o = '0;
      da_o  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         vld_o[PW'(i)] = mem_q[PW'(i)].vld;
         da_o[PW'(i)]  = mem_q[PW'(i)].da;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU (priority, unstallable) vs queued LSU results,
// plus operand bypass and RAW hazard flags. Optional counters under WB_STATS_EN.
module regfile_writeback
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_da,
   input  logic [DW-1:0] alu_data,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_da,
   input  logic [DW-1:0] lsu_data,
   output logic          RW,
   output logic [AW-1:0] DA,
   output logic [DW-1:0] BUS_D,
   input  logic [AW-1:0] AA,
   input  logic [AW-1:0] BA,
   output logic          fwd_a_hit,
   output logic [DW-1:0] fwd_a_data,
   output logic          fwd_b_hit,
   output logic [DW-1:0] fwd_b_data,
   output logic          raw_hazard,
`ifdef WB_STATS_EN
   output logic [15:0]   stat_squash,
   output logic [15:0]   stat_full,
`endif
   output logic          wb_full
);

   logic                      alu_acc, push, pop;
   logic                      fifo_empty, fifo_full;
   wb_entry_t                 push_entry, head;
   logic [DEPTH-1:0]          fifo_vld;
   logic [DEPTH-1:0][AW-1:0]  fifo_da;

   logic                      rw_q, rw_d;
   logic [AW-1:0]             da_q, da_d;
   logic [DW-1:0]             data_q, data_d;

   // Writes to r0 are dropped before they touch anything.
   assign alu_acc    = alu_valid && (alu_da != '0);
   assign lsu_ready  = !fifo_full;
   assign push       = lsu_valid && lsu_ready && (lsu_da != '0) &&
                       !(alu_acc && (lsu_da == alu_da));
   assign pop        = !alu_acc && !fifo_empty;
   assign push_entry = '{vld: 1'b1, da: lsu_da, data: lsu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .squash_i     (alu_acc),
      .squash_da_i  (alu_da),
      .head_o       (head),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full),
      .vld_o        (fifo_vld),
      .da_o         (fifo_da)
   );

   // Squashed entries pop with RW=0 and leave DA/BUS_D untouched.
   always_comb begin
      rw_d   = 1'b0;
      da_d   = da_q;
      data_d = data_q;
      if (alu_acc) begin
         rw_d   = 1'b1;
         da_d   = alu_da;
         data_d = alu_data;
      end else if (pop && head.vld) begin
         rw_d   = 1'b1;
         da_d   = head.da;
         data_d = head.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_q   <= 1'b0;
         da_q   <= '0;
         data_q <= '0;
      end else begin
         rw_q   <= rw_d;
         da_q   <= da_d;
         data_q <= data_d;
      end
   end

   assign RW    = rw_q;
   assign DA    = da_q;
   assign BUS_D = data_q;

   assign fwd_a_hit  = rw_q && (da_q == AA) && (AA != '0);
   assign fwd_b_hit  = rw_q && (da_q == BA) && (BA != '0);
   assign fwd_a_data = data_q;
   assign fwd_b_data = data_q;

   always_comb begin
      raw_hazard = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_vld[i] && (((fifo_da[i] == AA) && (AA != '0)) ||
                             ((fifo_da[i] == BA) && (BA != '0)))) begin
            raw_hazard = 1'b1;
         end
      end
   end

   assign wb_full = fifo_full;

`ifdef WB_STATS_EN
   logic [15:0] sq_q, sq_d, fl_q, fl_d;
   logic [16:0] sq_sum;

   // Saturating counters; the squash count sums every live entry matching the ALU target.
   always_comb begin
      sq_sum = {1'b0, sq_q};
      if (alu_acc) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_da[i] == alu_da)) begin
               sq_sum = sq_sum + 17'(1);
            end
         end
      end
      sq_d = sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
      fl_d = (fifo_full && (fl_q != 16'hFFFF)) ? fl_q + 16'd1 : fl_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= '0;
         fl_q <= '0;
      end else begin
         sq_q <= sq_d;
         fl_q <= fl_d;
      end
   end

   assign stat_squash = sq_q;
   assign stat_full   = fl_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU path, LSU queue, fill, squash, r0 drop, async reset.
module tb_regfile_writeback;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_da;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_da;
   logic [31:0] lsu_data;
   logic        RW;
   logic [4:0]  DA;
   logic [31:0] BUS_D;
   logic [4:0]  AA, BA;
   logic        fwd_a_hit, fwd_b_hit;
   logic [31:0] fwd_a_data, fwd_b_data;
   logic        raw_hazard;
   logic        wb_full;
`ifdef WB_STATS_EN
   logic [15:0] stat_squash, stat_full;
`endif

   int tests = 0;
   int fails = 0;

   regfile_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_da     (alu_da),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_da     (lsu_da),
      .lsu_data   (lsu_data),
      .RW         (RW),
      .DA         (DA),
      .BUS_D      (BUS_D),
      .AA         (AA),
      .BA         (BA),
      .fwd_a_hit  (fwd_a_hit),
      .fwd_a_data (fwd_a_data),
      .fwd_b_hit  (fwd_b_hit),
      .fwd_b_data (fwd_b_data),
      .raw_hazard (raw_hazard),
`ifdef WB_STATS_EN
      .stat_squash(stat_squash),
      .stat_full  (stat_full),
`endif
      .wb_full    (wb_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_da = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_da = '0; lsu_data = '0;
   endtask

   initial begin
      idle_inputs();
      AA = '0; BA = '0;
      rst_n = 1'b0;
      #2;
      chk("rst_rw",    32'(RW), 32'd0);
      chk("rst_da",    32'(DA), 32'd0);
      chk("rst_busd",  BUS_D, 32'd0);
      chk("rst_ready", 32'(lsu_ready), 32'd1);
      chk("rst_full",  32'(wb_full), 32'd0);
      chk("rst_raw",   32'(raw_hazard), 32'd0);
      #10;
      rst_n = 1'b1;

      // 1: ALU only
      alu_valid = 1'b1; alu_da = 5'd3; alu_data = 32'hDEAD_BEEF;
      tick();
      idle_inputs();
      AA = 5'd3;
      #1;
      chk("t1_rw",    32'(RW), 32'd1);
      chk("t1_da",    32'(DA), 32'd3);
      chk("t1_busd",  BUS_D, 32'hDEAD_BEEF);
      chk("t1_fwda",  32'(fwd_a_hit), 32'd1);
      chk("t1_fwdad", fwd_a_data, 32'hDEAD_BEEF);
      chk("t1_fwdb",  32'(fwd_b_hit), 32'd0);
      tick();
      chk("t1_rw_off", 32'(RW), 32'd0);
      chk("t1_fwda_off", 32'(fwd_a_hit), 32'd0);
      chk("t1_da_hold", 32'(DA), 32'd3);
      AA = '0;

      // 2: LSU push while ALU idle, presented two cycles later
      lsu_valid = 1'b1; lsu_da = 5'd7; lsu_data = 32'd5;
      #1;
      chk("t2_ready", 32'(lsu_ready), 32'd1);
      tick();
      idle_inputs();
      BA = 5'd7;
      #1;
      chk("t2_n1_rw",  32'(RW), 32'd0);
      chk("t2_n1_raw", 32'(raw_hazard), 32'd1);
      tick();
      chk("t2_n2_rw",   32'(RW), 32'd1);
      chk("t2_n2_da",   32'(DA), 32'd7);
      chk("t2_n2_busd", BUS_D, 32'd5);
      chk("t2_n2_raw",  32'(raw_hazard), 32'd0);
      chk("t2_n2_fwdb", 32'(fwd_b_hit), 32'd1);
      tick();
      chk("t2_drain_rw", 32'(RW), 32'd0);
      BA = '0;

      // 3: fill the queue under continuous ALU traffic
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1'b1; alu_da = 5'(k + 1); alu_data = 32'h1000 + 32'(k);
         lsu_valid = 1'b1; lsu_da = 5'(k + 10); lsu_data = 32'd100 + 32'(k);
         #1;
         chk("t3_ready_fill", 32'(lsu_ready), 32'd1);
         tick();
         chk("t3_alu_da", 32'(DA), 32'(k + 1));
         chk("t3_alu_busd", BUS_D, 32'h1000 + 32'(k));
      end
      chk("t3_full",   32'(wb_full), 32'd1);
      chk("t3_nready", 32'(lsu_ready), 32'd0);
      alu_valid = 1'b1; alu_da = 5'd5; alu_data = 32'h2000;
      lsu_valid = 1'b1; lsu_da = 5'd14; lsu_data = 32'd999;
      tick();
      chk("t3_alu5_da", 32'(DA), 32'd5);
      chk("t3_still_full", 32'(wb_full), 32'd1);
      idle_inputs();
      tick();
      chk("t3_pop_rw",   32'(RW), 32'd1);
      chk("t3_pop_da",   32'(DA), 32'd10);
      chk("t3_pop_busd", BUS_D, 32'd100);
      chk("t3_pop_full", 32'(wb_full), 32'd0);
      chk("t3_pop_ready", 32'(lsu_ready), 32'd1);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t3_drain_da",   32'(DA), 32'(k + 10));
         chk("t3_drain_busd", BUS_D, 32'd100 + 32'(k));
      end
      tick();
      chk("t3_empty_rw", 32'(RW), 32'd0);

      // 4: ALU overwrite squashes a queued entry
      lsu_valid = 1'b1; lsu_da = 5'd9; lsu_data = 32'd1;
      tick();
      idle_inputs();
      AA = 5'd9;
      #1;
      chk("t4_raw_queued", 32'(raw_hazard), 32'd1);
      alu_valid = 1'b1; alu_da = 5'd9; alu_data = 32'd2;
      tick();
      idle_inputs();
      chk("t4_rw",   32'(RW), 32'd1);
      chk("t4_da",   32'(DA), 32'd9);
      chk("t4_busd", BUS_D, 32'd2);
      chk("t4_raw_squashed", 32'(raw_hazard), 32'd0);
`ifdef WB_STATS_EN
      chk("t4_stat_squash", 32'(stat_squash), 32'd1);
`endif
      tick();
      chk("t4_drain_rw",   32'(RW), 32'd0);
      chk("t4_drain_busd", BUS_D, 32'd2);
      tick();
      chk("t4_idle_rw", 32'(RW), 32'd0);
      AA = '0;

      // 5: writes to r0 are dropped
      alu_valid = 1'b1; alu_da = 5'd0; alu_data = 32'h1234;
      lsu_valid = 1'b1; lsu_da = 5'd0; lsu_data = 32'h5678;
      #1;
      chk("t5_ready", 32'(lsu_ready), 32'd1);
      tick();
      idle_inputs();
      chk("t5_rw0", 32'(RW), 32'd0);
      chk("t5_fwda", 32'(fwd_a_hit), 32'd0);
      chk("t5_raw", 32'(raw_hazard), 32'd0);
      tick();
      chk("t5_rw1", 32'(RW), 32'd0);
      chk("t5_full", 32'(wb_full), 32'd0);

      // 6: async reset with three entries queued and RW high
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_da = 5'(k + 20); alu_data = 32'(k);
         lsu_valid = 1'b1; lsu_da = 5'(k + 23); lsu_data = 32'(k + 50);
         tick();
      end
      idle_inputs();
      AA = 5'd23;
      #1;
      chk("t6_rw_before", 32'(RW), 32'd1);
      chk("t6_raw_before", 32'(raw_hazard), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rw_async", 32'(RW), 32'd0);
      chk("t6_ready_async", 32'(lsu_ready), 32'd1);
      chk("t6_raw_async", 32'(raw_hazard), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      chk("t6_rw_after", 32'(RW), 32'd0);
      chk("t6_ready_after", 32'(lsu_ready), 32'd1);
      chk("t6_full_after", 32'(wb_full), 32'd0);
      tick();
      chk("t6_rw_after2", 32'(RW), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
